se_gap_accum: RTL
=================

# se_gap_accum

Global-average-pool accumulator for the SE block, sitting directly upstream of the 16-lane channel divider. It takes a stream of 16-channel activation vectors (one per spatial position) and keeps a widened running sum per channel. It also counts positions. On the last position of a frame it presents the 16 sums and the position count as dividends and divisor, starts the divider, and holds those operands stable until the divider reports done.

## Interface
- `WIDTH`, 14, signed fixed-point width of each activation lane (integer + fractional).
- `FBITS`, 7, fractional bits of each activation lane.
- `IN_WIDTH`, WIDTH+12, accumulator width per lane; matches the divider's dividend width.
- `CNT_W`, 12, width of the position counter; a frame holds at most 2^CNT_W−1 positions.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  activation beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_last`  in  1  marks the final beat of a frame; qualified by `in_valid`.
- `in_data`  in  16*WIDTH  packed signed activations; lane i occupies bits [WIDTH*(i+1)-1 : WIDTH*i].
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_busy`  in  1  divider busy; monitored only, no control effect.
- `div_done`  in  1  divider finished.
- `div_dividends`  out  16*IN_WIDTH  packed signed per-lane sums; lane i occupies bits [IN_WIDTH*(i+1)-1 : IN_WIDTH*i].
- `div_divisor`  out  IN_WIDTH  position count in Q(FBITS), always positive.
- `frame_done`  out  1  one-cycle pulse when the divider completes for this frame.
- `ovf_err`  out  1  sticky flag: a frame exceeded 2^CNT_W−1 positions.

## Operation
- **States:**
  - `ACC` is the reset state; `in_ready`=1.
  - `START`: `div_start`=1, `in_ready`=0.
  - `WAIT`: `in_ready`=0.
- **Beat acceptance:** a beat is accepted when `in_valid` & `in_ready`.
  - Each lane sum becomes sum + sign_extend(`in_data` lane) to IN_WIDTH. Addition is two's complement with no saturation.
  - `cnt` increments by 1.
- **ACC → START:** on an accepted beat with `in_last`=1. The last beat is included in the sums and in `cnt`.
- **START → WAIT:** unconditionally after one cycle.
- **WAIT → ACC:** on the first cycle with `div_done`=1.
  - `frame_done` pulses in that cycle.
  - All sums and `cnt` are cleared to 0.
- **`div_dividends`:** driven directly from the sum registers. Stable throughout `START` and `WAIT`, because no beats are accepted in those states.
- **`div_divisor`:** zero_extend(`cnt`) << FBITS, truncated to IN_WIDTH, so the quotient is in Q(FBITS).
- **Count overflow:** a beat accepted while `cnt` = 2^CNT_W−1 is not accumulated and `cnt` does not change. `ovf_err` is set and stays set until `rst`. The beat's `in_last` is still honoured.
- **Width guarantee:** for any legal count, IN_WIDTH = WIDTH+12 ≥ WIDTH+CNT_W, so the sums never overflow.
- **`div_busy`:** ignored by the control logic.

## Timing
- **Reset values:** state=`ACC`; all sums 0; `cnt`=0; `div_start`=0; `frame_done`=0; `ovf_err`=0; `in_ready`=0 during the reset cycle, then 1.
- **Accumulation latency:** an accepted beat at cycle t is reflected in the sums and `cnt` at t+1.
- **Divider launch:** the last beat is accepted at cycle t. `div_start`=1 at t+1 only. `in_ready` is 0 from t+1 until the cycle after `div_done` is seen.
- **`div_done` in START:** a `div_done` level present during the `START` cycle is ignored; it is only sampled in `WAIT`.
- **Return to ACC:** `div_done` seen in `WAIT` at cycle d gives `frame_done`=1 at d and `in_ready`=1 at d+1, with the next frame starting from cleared sums.
- **Back-to-back frames:** throughput is one beat per cycle within a frame. Between frames there is a stall of 2 + divider latency cycles.
- **Reset mid-frame:** `rst` in any state abandons the frame. No `div_start` or `frame_done` is issued for it; the divider shares `rst`.

## Test plan
- **Basic frame:** 4 beats with every lane i = (i+1)<<7, `in_last` on beat 4.
  - Required: `div_dividends` lane i = 4*(i+1)*128 (lane 0 = 512), `div_divisor` = 512.
  - Required: `div_start` pulses exactly once, one cycle after beat 4.
  - Then drive `div_done` after 20 cycles. Required: `frame_done` in that cycle, sums equal 0 on the next cycle.
- **Signed values:** 2 beats, lane 0 = −256 then +128. Required: lane 0 dividend = −128, sign-extended to IN_WIDTH; `div_divisor` = 256.
- **Backpressure:** hold `in_valid`=1 during `START`/`WAIT`. Required: `in_ready`=0, and sums stay unchanged until the cycle after `div_done`.
- **Single-beat frame:** one beat with `in_last`. Required: `div_divisor` = 128, dividends equal the input lanes sign-extended.
- **Count overflow (CNT_W=3):** 9 beats of value 1 on all lanes. Required: `cnt` stops at 7, sums = 7, `ovf_err`=1, and `ovf_err` stays set after the next frame.
- **Reset in WAIT:** assert `rst` during `WAIT`. Required: state=`ACC` on the next cycle, sums=0, no `frame_done`; a subsequent clean frame gives correct sums.

Source files
------------

// File: rtl/se_gap_accum.sv
// Global-average-pool accumulator for the SE block: sums 16 activation lanes per frame,
// counts positions, then hands sums and Q(FBITS) count to the channel divider.
module se_gap_accum #(
  parameter int WIDTH    = 14,
  parameter int FBITS    = 7,
  parameter int IN_WIDTH = WIDTH + 12,
  parameter int CNT_W    = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [16*WIDTH-1:0]      in_data,
  output logic                     div_start,
  input  logic                     div_busy,
  input  logic                     div_done,
  output logic [16*IN_WIDTH-1:0]   div_dividends,
  output logic [IN_WIDTH-1:0]      div_divisor,
  output logic                     frame_done,
  output logic                     ovf_err
);

  localparam int LANES = 16;

  typedef enum logic [1:0] {ACC, START, WAIT} state_t;

  state_t                      state;
  logic signed [IN_WIDTH-1:0]  acc_p1 [LANES];
  logic [CNT_W-1:0]            cnt_p1;
  logic                        accept;
  logic                        cnt_full;
  logic                        busy_unused;

  function automatic logic signed [IN_WIDTH-1:0] sext_lane(input logic signed [WIDTH-1:0] v);
    return IN_WIDTH'(v);
  endfunction

  function automatic logic [IN_WIDTH-1:0] q_divisor(input logic [CNT_W-1:0] c);
    logic [IN_WIDTH+CNT_W+FBITS-1:0] w;
    w = {{IN_WIDTH{1'b0}}, c, {FBITS{1'b0}}};
    return w[IN_WIDTH-1:0];
  endfunction

  assign busy_unused = div_busy;
  assign in_ready    = (state == ACC) && !rst;
  assign accept      = in_valid && in_ready;
  assign cnt_full    = (cnt_p1 == {CNT_W{1'b1}});
  assign div_start   = (state == START);
  assign frame_done  = (state == WAIT) && div_done;
  assign div_divisor = q_divisor(cnt_p1);

  always_comb begin
    div_dividends = '0;
    for (int i = 0; i < LANES; i++)
      div_dividends[i*IN_WIDTH +: IN_WIDTH] = acc_p1[i];
  end

  // Stage p1: per-lane running sums and position count, updated on accepted beats
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACC;
      cnt_p1  <= '0;
      ovf_err <= 1'b0;
      for (int i = 0; i < LANES; i++) acc_p1[i] <= '0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            // A full counter drops the beat's data but still honours its in_last.
            if (!cnt_full) begin
              cnt_p1 <= cnt_p1 + CNT_W'(1);
              for (int i = 0; i < LANES; i++)
                acc_p1[i] <= acc_p1[i] + sext_lane(in_data[i*WIDTH +: WIDTH]);
            end else begin
              ovf_err <= 1'b1;
            end
            if (in_last) state <= START;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (div_done) begin
            state  <= ACC;
            cnt_p1 <= '0;
            for (int i = 0; i < LANES; i++) acc_p1[i] <= '0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
